// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers, imported by the sync
// generator, the sprite blocks and the final colour stage.
package vga_timing_pkg;

  localparam int unsigned COORD_W   = 10;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Inclusive sync windows
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_VISIBLE + H_FRONT + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_VISIBLE + V_FRONT + V_SYNC - 1;

  function automatic logic inWindow(input logic [COORD_W-1:0] pos,
                                    input logic [COORD_W-1:0] lo,
                                    input logic [COORD_W-1:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel-rate divider: tick is high in the last system clock of each pixel
// period, i.e. every cycle when CLK_DIV is 1.
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] divCnt;

  assign tick = (divCnt == DIV_LAST);

  // divider phase counter, restarted by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt <= 4'd0;
    end else if (tick) begin
      divCnt <= 4'd0;
    end else begin
      divCnt <= divCnt + 4'd1;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: h/v position counters with every output
// decoded from the next position and registered on the same tick edge.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
  parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] hPos,
  output logic [COORD_W-1:0] vPos,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic               pixTick,
  output logic               lineStart,
  output logic               frameStart
);

  localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [COORD_W-1:0] H_VIS   = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS   = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_LO   = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_HI   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_LO   = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_HI   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic               tick;
  logic [COORD_W-1:0] hNext;
  logic [COORD_W-1:0] vNext;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) uDiv (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // next-position decode, both wraps resolved in one step
  always_comb begin
    hNext = hPos + 10'd1;
    vNext = vPos;
    if (hPos == H_LAST) begin
      hNext = 10'd0;
      if (vPos == V_LAST) begin
        vNext = 10'd0;
      end else begin
        vNext = vPos + 10'd1;
      end
    end else begin
      vNext = vPos;
    end
  end

  // position and output registers, loaded together so they never skew
  always_ff @(posedge clk) begin
    if (rst) begin
      hPos       <= H_LAST;
      vPos       <= V_LAST;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      active     <= 1'b0;
      pixTick    <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else if (tick) begin
      hPos       <= hNext;
      vPos       <= vNext;
      hsync      <= inWindow(hNext, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
      vsync      <= inWindow(vNext, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
      active     <= (hNext < H_VIS) && (vNext < V_VIS);
      pixTick    <= 1'b1;
      lineStart  <= (hNext == 10'd0);
      frameStart <= (hNext == 10'd0) && (vNext == 10'd0);
    end else begin
      pixTick    <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end
  end

endmodule
